// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer
// Description : Game-round FSM for the bomb-defuse puzzle: arm, show password,
//               timed entry with error budget, result hold, optional repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer #(
    parameter int TICK_DIV   = 50000000,
    parameter int SHOW_SEC   = 5,
    parameter int INPUT_SEC  = 20,
    parameter int RESULT_SEC = 3,
    parameter int MAX_ERR    = 3
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       en,
    input  logic       start_btn,
    input  logic       auto_repeat,
    input  logic       code_ok,
    input  logic       code_bad,
    output logic [2:0] state,
    output logic       round_rst,
    output logic       show_en,
    output logic       input_en,
    output logic       bomb_en,
    output logic [4:0] countdown,
    output logic [1:0] err_cnt,
    output logic       success,
    output logic       fail,
    output logic [4:0] random
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SHOW    = 3'd2,
        S_INPUT   = 3'd3,
        S_SUCCESS = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    localparam int                 c_DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [4:0]         c_SHOW     = 5'(SHOW_SEC);
    localparam logic [4:0]         c_INPUT    = 5'(INPUT_SEC);
    localparam logic [4:0]         c_RESULT   = 5'(RESULT_SEC);
    localparam logic [1:0]         c_MAX_ERR  = 2'(MAX_ERR);

    state_t               r_state_q, w_state_d;
    logic                 r_start_prev_q;
    logic [c_DIV_W-1:0]   r_div_q, w_div_d;
    logic [4:0]           r_cd_q, w_cd_d;
    logic [1:0]           r_err_q, w_err_d;
    logic [4:0]           r_lfsr_q, w_lfsr_d;
    logic [4:0]           r_rand_q, w_rand_d;
    logic                 r_round_rst_q, w_round_rst_d;
    logic                 r_show_en_q, w_show_en_d;
    logic                 r_input_en_q, w_input_en_d;
    logic                 r_bomb_en_q, w_bomb_en_d;
    logic                 r_success_q, w_success_d;
    logic                 r_fail_q, w_fail_d;

    logic                 w_start_edge;
    logic                 w_tick;
    logic                 w_expire;
    logic                 w_entry;
    logic [1:0]           w_err_inc;

    assign w_start_edge = start_btn & ~r_start_prev_q;
    assign w_tick       = (r_div_q == c_DIV_LAST);
    assign w_expire     = w_tick && (r_cd_q == 5'd1);
    assign w_err_inc    = r_err_q + 2'd1;
    assign w_entry      = (w_state_d != r_state_q);

    always_comb begin
        w_state_d = r_state_q;
        if (!en) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state_q)
                S_IDLE:    if (w_start_edge) w_state_d = S_ARM;
                S_ARM:     w_state_d = S_SHOW;
                S_SHOW:    if (w_expire) w_state_d = S_INPUT;
                S_INPUT: begin
                    // A correct code wins over both a wrong code and timeout.
                    if (code_ok)
                        w_state_d = S_SUCCESS;
                    else if ((code_bad && (w_err_inc == c_MAX_ERR)) || w_expire)
                        w_state_d = S_FAIL;
                end
                S_SUCCESS,
                S_FAIL:    if (w_expire) w_state_d = auto_repeat ? S_ARM : S_IDLE;
                default:   w_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_div_d  = (w_entry || w_tick) ? '0 : r_div_q + c_DIV_W'(1);
        w_cd_d   = r_cd_q;
        if (w_entry) begin
            case (w_state_d)
                S_SHOW:           w_cd_d = c_SHOW;
                S_INPUT:          w_cd_d = c_INPUT;
                S_SUCCESS, S_FAIL: w_cd_d = c_RESULT;
                default:          w_cd_d = 5'd0;
            endcase
        end else if (w_tick && (r_cd_q != 5'd0)) begin
            w_cd_d = r_cd_q - 5'd1;
        end

        w_err_d = r_err_q;
        if (r_state_q == S_ARM)
            w_err_d = 2'd0;
        else if (en && (r_state_q == S_INPUT) && code_bad && !code_ok)
            w_err_d = w_err_inc;

        w_lfsr_d      = {r_lfsr_q[3:0], r_lfsr_q[4] ^ r_lfsr_q[2]};
        w_rand_d      = (r_state_q == S_ARM) ? r_lfsr_q : r_rand_q;
        // Abort via en also clears the per-round modules.
        w_round_rst_d = (w_state_d == S_ARM) || (!en && (r_state_q != S_IDLE));
        w_show_en_d   = (w_state_d == S_SHOW);
        w_input_en_d  = (w_state_d == S_INPUT);
        w_bomb_en_d   = (w_state_d == S_SHOW) || (w_state_d == S_INPUT);
        w_success_d   = (w_state_d == S_SUCCESS);
        w_fail_d      = (w_state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state_q      <= S_IDLE;
            r_start_prev_q <= 1'b1;
            r_div_q        <= '0;
            r_cd_q         <= 5'd0;
            r_err_q        <= 2'd0;
            r_lfsr_q       <= 5'b00001;
            r_rand_q       <= 5'd0;
            r_round_rst_q  <= 1'b0;
            r_show_en_q    <= 1'b0;
            r_input_en_q   <= 1'b0;
            r_bomb_en_q    <= 1'b0;
            r_success_q    <= 1'b0;
            r_fail_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_start_prev_q <= start_btn;
            r_div_q        <= w_div_d;
            r_cd_q         <= w_cd_d;
            r_err_q        <= w_err_d;
            r_lfsr_q       <= w_lfsr_d;
            r_rand_q       <= w_rand_d;
            r_round_rst_q  <= w_round_rst_d;
            r_show_en_q    <= w_show_en_d;
            r_input_en_q   <= w_input_en_d;
            r_bomb_en_q    <= w_bomb_en_d;
            r_success_q    <= w_success_d;
            r_fail_q       <= w_fail_d;
        end
    end

    assign state     = r_state_q;
    assign round_rst = r_round_rst_q;
    assign show_en   = r_show_en_q;
    assign input_en  = r_input_en_q;
    assign bomb_en   = r_bomb_en_q;
    assign countdown = r_cd_q;
    assign err_cnt   = r_err_q;
    assign success   = r_success_q;
    assign fail      = r_fail_q;
    assign random    = r_rand_q;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_sequencer
// Description : Directed self-checking bench for round_sequencer (TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_p, en, start_btn, auto_repeat, code_ok, code_bad;
    logic [2:0] state;
    logic       round_rst, show_en, input_en, bomb_en, success, fail;
    logic [4:0] countdown, random;
    logic [1:0] err_cnt;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n;
    logic [4:0] m_lfsr;
    logic [4:0] exp_rand;

    round_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_p(rst_p), .en(en), .start_btn(start_btn),
        .auto_repeat(auto_repeat), .code_ok(code_ok), .code_bad(code_bad),
        .state(state), .round_rst(round_rst), .show_en(show_en),
        .input_en(input_en), .bomb_en(bomb_en), .countdown(countdown),
        .err_cnt(err_cnt), .success(success), .fail(fail), .random(random)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] lfsr_step(input logic [4:0] x);
        return {x[3:0], x[4] ^ x[2]};
    endfunction

    // Reference x^5+x^3+1 sequence, seeded like the design.
    always @(posedge clk) m_lfsr <= rst_p ? 5'b00001 : lfsr_step(m_lfsr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int cnt);
        cnt = 0;
        while (state != s && cnt < max) begin
            @(negedge clk);
            cnt++;
        end
        check("wait_state", 32'(state), 32'(s));
    endtask

    task automatic start_round();
        start_btn = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        check("arm_state", 32'(state), 1);
        check("arm_round_rst", 32'(round_rst), 1);
        check("arm_countdown", 32'(countdown), 0);
        exp_rand = m_lfsr;
        @(negedge clk);
        check("show_state", 32'(state), 2);
        check("show_round_rst", 32'(round_rst), 0);
        check("show_random", 32'(random), 32'(exp_rand));
        check("show_enables", 32'({show_en, input_en, bomb_en}), 32'b101);
    endtask

    task automatic pulse_bad();
        code_bad = 1'b1;
        @(negedge clk);
        code_bad = 1'b0;
    endtask

    initial begin
        rst_p = 1'b1; en = 1'b0; start_btn = 1'b0; auto_repeat = 1'b0;
        code_ok = 1'b0; code_bad = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({state, round_rst, show_en, input_en, bomb_en,
                                 countdown, err_cnt, success, fail}), 0);
        check("reset_random", 32'(random), 0);
        rst_p = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold", 32'(state), 0);

        // Round 1: full SHOW countdown, then three wrong codes
        start_round();
        for (int k = 0; k < 20; k++) begin
            check("show_cd", 32'(countdown), 32'(5 - k / 4));
            @(negedge clk);
        end
        check("input_state", 32'(state), 3);
        check("input_cd", 32'(countdown), 20);
        check("input_enables", 32'({show_en, input_en, bomb_en}), 32'b011);
        pulse_bad();
        check("err1", 32'(err_cnt), 1);
        check("err1_state", 32'(state), 3);
        @(negedge clk);
        pulse_bad();
        check("err2", 32'(err_cnt), 2);
        @(negedge clk);
        pulse_bad();
        check("err3_state", 32'(state), 5);
        check("err3_cnt", 32'(err_cnt), 3);
        check("err3_fail", 32'(fail), 1);
        check("err3_cd", 32'(countdown), 3);
        check("fail_enables", 32'({show_en, input_en, bomb_en, success}), 0);
        wait_state(3'd0, 40, n);
        check("fail_hold", n, 12);
        check("idle_fail_low", 32'(fail), 0);

        // Round 2: codes ignored in SHOW, INPUT expires after 80 cycles
        start_round();
        code_ok = 1'b1; code_bad = 1'b1;
        @(negedge clk);
        code_ok = 1'b0; code_bad = 1'b0;
        check("ignore_state", 32'(state), 2);
        check("ignore_err", 32'(err_cnt), 0);
        wait_state(3'd3, 40, n);
        check("show_rest", n, 19);
        wait_state(3'd5, 200, n);
        check("input_expiry", n, 80);
        wait_state(3'd0, 40, n);

        // Round 3: code_ok on the expiry cycle wins
        start_round();
        wait_state(3'd3, 40, n);
        repeat (79) @(negedge clk);
        check("last_cycle_state", 32'(state), 3);
        check("last_cycle_cd", 32'(countdown), 1);
        code_ok = 1'b1;
        @(negedge clk);
        code_ok = 1'b0;
        check("ok_at_expiry", 32'(state), 4);
        check("ok_success", 32'(success), 1);
        check("ok_cd", 32'(countdown), 3);
        wait_state(3'd0, 40, n);
        check("success_hold", n, 12);

        // Round 4: ok+bad together, then auto repeat
        auto_repeat = 1'b1;
        start_round();
        wait_state(3'd3, 40, n);
        pulse_bad();
        check("r4_err1", 32'(err_cnt), 1);
        code_ok = 1'b1; code_bad = 1'b1;
        @(negedge clk);
        code_ok = 1'b0; code_bad = 1'b0;
        check("both_state", 32'(state), 4);
        check("both_err", 32'(err_cnt), 1);
        wait_state(3'd1, 40, n);
        check("repeat_hold", n, 12);
        check("repeat_round_rst", 32'(round_rst), 1);
        exp_rand = m_lfsr;
        @(negedge clk);
        check("repeat_show", 32'(state), 2);
        check("repeat_random", 32'(random), 32'(exp_rand));
        check("repeat_err_clr", 32'(err_cnt), 0);

        // en dropped mid-SHOW
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_state", 32'(state), 0);
        check("en_drop_round_rst", 32'(round_rst), 1);
        check("en_drop_outs", 32'({show_en, input_en, bomb_en, success, fail, countdown}), 0);
        @(negedge clk);
        check("en_drop_pulse_end", 32'(round_rst), 0);
        auto_repeat = 1'b0;

        // start_btn held through reset release must not start a round
        start_btn = 1'b1;
        rst_p     = 1'b1;
        en        = 1'b1;
        repeat (2) @(negedge clk);
        rst_p = 1'b0;
        repeat (5) @(negedge clk);
        check("held_btn_idle", 32'(state), 0);

        // Reset mid-round aborts without round_rst
        start_round();
        repeat (3) @(negedge clk);
        rst_p = 1'b1;
        @(negedge clk);
        check("rst_mid_state", 32'(state), 0);
        check("rst_mid_outs", 32'({round_rst, show_en, bomb_en, countdown}), 0);
        rst_p = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
